// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the
// MEM stage. Each request is serialised into consecutive byte accesses;
// read bytes are assembled little-endian into a zero-extended word.

// One byte lane of the read assembly buffer.
module mem_ctrl_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       cap,
  input  logic [7:0] din,
  output logic [7:0] nxt
);
  logic [7:0] q;

  // Post-edge lane value, so the final byte joins the word on the edge it arrives.
  always_comb nxt = cap ? din : q;

  // Hold the captured byte; cleared at every grant so unread bytes stay zero.
  always_ff @(posedge clk) begin
    if (!rst || clr) q <= '0;
    else             q <= nxt;
  end
endmodule

module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              stall_req
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // Transaction latched at the grant edge.
  typedef struct packed {
    logic              src_mem;
    logic              we;
    logic [2:0]        n;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
  } xact_t;

  state_t                       state, state_nxt;
  xact_t                        xa, xa_nxt;
  logic [2:0]                   k, k_nxt;
  logic                         grant, abort, last_byte;
  logic                         cap_vld;
  logic [1:0]                   cap_k;
  logic [NUM_LANES-1:0]         lane_cap;
  logic [NUM_LANES-1:0][7:0]    lane_nxt;
  logic [31:0]                  rd_word;

  // Arbitration (MEM over IF), byte sequencing and IF flush abort.
  always_comb begin
    state_nxt = state;
    xa_nxt    = xa;
    grant     = 1'b0;
    abort     = 1'b0;
    last_byte = (k == xa.n - 3'd1);
    case (state)
      IDLE: begin
        if (mem_req) begin
          grant          = 1'b1;
          xa_nxt.src_mem = 1'b1;
          xa_nxt.we      = mem_we;
          xa_nxt.n       = (mem_len == 2'b00) ? 3'd1 :
                           (mem_len == 2'b01) ? 3'd2 : 3'd4;
          xa_nxt.base    = mem_addr;
          xa_nxt.wdata   = mem_wdata;
        end else if (if_req && !if_flush) begin
          grant          = 1'b1;
          xa_nxt.src_mem = 1'b0;
          xa_nxt.we      = 1'b0;
          xa_nxt.n       = 3'd4;
          xa_nxt.base    = if_addr;
          xa_nxt.wdata   = '0;
        end
        if (grant) state_nxt = ACCESS;
      end
      ACCESS:  if (last_byte) state_nxt = xa.we ? DONE : WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A flush kills any fetch in flight; MEM transactions ignore it.
    if (state != IDLE && !xa.src_mem && if_flush) begin
      abort     = 1'b1;
      state_nxt = IDLE;
    end
  end

  // Byte index advances only while staying in ACCESS; every entry starts at 0.
  always_comb k_nxt = (state == ACCESS && state_nxt == ACCESS) ? k + 3'd1 : 3'd0;

  // State, transaction context, read-capture tracking and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      xa        <= '0;
      k         <= '0;
      cap_vld   <= 1'b0;
      cap_k     <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      state   <= state_nxt;
      xa      <= xa_nxt;
      k       <= k_nxt;
      // RAM returns data one cycle after the address, so remember which byte is due.
      cap_vld <= (state == ACCESS) && !xa.we && !abort;
      cap_k   <= k[1:0];
      if (state == WAIT && !abort) begin
        if (xa.src_mem) mem_rdata <= rd_word;
        else            if_inst   <= rd_word;
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_cap[i] = cap_vld && (cap_k == 2'(i));
    mem_ctrl_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (grant),
      .cap (lane_cap[i]),
      .din (ram_din),
      .nxt (lane_nxt[i])
    );
  end

  assign rd_word = lane_nxt;

  // RAM port is driven only during ACCESS; quiet otherwise.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_dout = '0;
    if (state == ACCESS) begin
      ram_addr = xa.base + ADDR_W'(k);
      ram_we   = xa.we;
      ram_dout = xa.wdata[{k[1:0], 3'b000} +: 8];
    end
  end

  assign if_done   = (state == DONE) && !xa.src_mem && !if_flush;
  assign mem_done  = (state == DONE) && xa.src_mem;
  assign stall_req = (if_req & ~if_done) | (mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, vector table for
// single transactions, hand sequences for priority, wrap, flush and reset.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic        clk, rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr, if_inst;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout, ram_din;
  logic        stall_req;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_inst(if_inst), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
    .ram_din(ram_din), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sparse byte RAM, synchronous read.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk) begin
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    if (ram_we) ram[ram_addr] = ram_dout;
  end

  function automatic logic [7:0] peek(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle trace, index 0 = cycle in which the run started.
  logic [31:0] t_addr [32];
  logic [31:0] t_inst [32];
  logic [31:0] t_rdata[32];
  logic [7:0]  t_dout [32];
  logic        t_we   [32];
  logic        t_stall[32];
  logic        t_ifd  [32];
  logic        t_memd [32];

  // Record n cycles; a requester drops its req the cycle after its done.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      t_addr[c]  = ram_addr;  t_inst[c]  = if_inst;  t_rdata[c] = mem_rdata;
      t_dout[c]  = ram_dout;  t_we[c]    = ram_we;   t_stall[c] = stall_req;
      t_ifd[c]   = if_done;   t_memd[c]  = mem_done;
      @(posedge clk); #1;
      if (t_ifd[c])  if_req  = 1'b0;
      if (t_memd[c]) mem_req = 1'b0;
    end
  endtask

  function automatic int first_done(input logic is_mem, input int n);
    for (int c = 0; c < n; c++) if (is_mem ? t_memd[c] : t_ifd[c]) return c;
    return -1;
  endfunction

  function automatic int count_done(input logic is_mem, input int n);
    int s = 0;
    for (int c = 0; c < n; c++) if (is_mem ? t_memd[c] : t_ifd[c]) s++;
    return s;
  endfunction

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk;
    logic [31:0] data;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  sv;
    logic [31:0] wd;

    vt[0]  = '{1'b0, 1'b0, 2'd2, 32'h300, 32'h0,        6, 1'b1, 32'h44332211};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF, 5, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 2'd2, 32'h200, 32'h0,        6, 1'b1, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 1'b0, 2'd3, 32'h200, 32'h0,        6, 1'b1, 32'hDEADBEEF};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 32'h301, 32'h0,        4, 1'b1, 32'h00003322};
    vt[5]  = '{1'b1, 1'b0, 2'd2, 32'h302, 32'h0,        6, 1'b1, 32'h00004433};
    vt[6]  = '{1'b1, 1'b1, 2'd0, 32'h400, 32'h1234567E, 2, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 2'd1, 32'h3FE, 32'hAABBCCDD, 3, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 2'd2, 32'h3FE, 32'h0,        6, 1'b1, 32'h007ECCDD};
    vt[9]  = '{1'b1, 1'b0, 2'd0, 32'h3FF, 32'h0,        3, 1'b1, 32'h000000CC};
    vt[10] = '{1'b0, 1'b0, 2'd2, 32'h200, 32'h0,        6, 1'b1, 32'hDEADBEEF};

    ram[32'h4]   = 8'h13; ram[32'h5]   = 8'h00; ram[32'h6]   = 8'h50; ram[32'h7]   = 8'h00;
    ram[32'h103] = 8'hA5;
    ram[32'h300] = 8'h11; ram[32'h301] = 8'h22; ram[32'h302] = 8'h33; ram[32'h303] = 8'h44;

    rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {if_inst, mem_rdata, if_done, mem_done, ram_addr, ram_we, ram_dout},
          128'h0);
    check("reset_stall_idle", stall_req, 1'b0);
    if_req = 1'b1; if_addr = 32'h4;
    #1 check("reset_stall_comb", stall_req, 1'b1);

    // Word fetch at 0x4 straight out of reset: trace addresses and stall.
    @(posedge clk); #1;
    rst = 1'b1;
    run_cycles(8);
    for (int c = 1; c <= 4; c++)
      check($sformatf("fetch_addr%0d", c), {t_we[c], t_addr[c]}, {1'b0, 32'h4 + 32'(c - 1)});
    check("fetch_addr_wait", t_addr[5], 32'h0);
    check("fetch_done_cyc", first_done(1'b0, 8), 6);
    check("fetch_inst", t_inst[6], 32'h00500013);
    for (int c = 0; c < 8; c++) sv[c] = t_stall[c];
    check("fetch_stall", sv, 8'h3F);

    // Simultaneous requests: MEM byte load first, then the fetch.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h103;
    if_req  = 1'b1; if_addr = 32'h4;
    run_cycles(14);
    check("prio_mem_addr", t_addr[1], 32'h103);
    check("prio_mem_done", first_done(1'b1, 14), 3);
    check("prio_mem_data", t_rdata[3], 32'h000000A5);
    check("prio_if_addr", t_addr[5], 32'h4);
    check("prio_if_done", first_done(1'b0, 14), 10);
    check("prio_if_once", count_done(1'b0, 14), 1);
    check("prio_if_inst", t_inst[10], 32'h00500013);

    // Vector table: one transaction each.
    for (int i = 0; i < 11; i++) begin
      if (vt[i].is_mem) begin
        mem_req = 1'b1; mem_we = vt[i].we; mem_len = vt[i].len;
        mem_addr = vt[i].addr; mem_wdata = vt[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vt[i].addr;
      end
      run_cycles(10);
      check($sformatf("vec%0d_lat", i), first_done(vt[i].is_mem, 10), vt[i].lat);
      if (vt[i].chk)
        check($sformatf("vec%0d_data", i),
              vt[i].is_mem ? t_rdata[vt[i].lat] : t_inst[vt[i].lat], vt[i].data);
      if (vt[i].is_mem && vt[i].we && vt[i].len[1]) begin
        wd = vt[i].wdata;
        for (int c = 1; c <= 4; c++)
          check($sformatf("vec%0d_wr%0d", i, c), {t_we[c], t_addr[c], t_dout[c]},
                {1'b1, vt[i].addr + 32'(c - 1), wd[8*(c-1) +: 8]});
      end
    end

    // Half store across the top of the address space.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'h0000_5AC3;
    run_cycles(6);
    check("wrap_b0", {t_we[1], t_addr[1], t_dout[1]}, {1'b1, 32'hFFFF_FFFF, 8'hC3});
    check("wrap_b1", {t_we[2], t_addr[2], t_dout[2]}, {1'b1, 32'h0000_0000, 8'h5A});
    check("wrap_done", first_done(1'b1, 6), 3);
    check("wrap_quiet", {t_we[3], t_addr[3], t_dout[3]}, 41'h0);
    check("wrap_ram", {peek(32'hFFFF_FFFF), peek(32'h0)}, 16'hC35A);

    // Flush in G+3 of a fetch, then redirect to 0x4.
    mem_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    run_cycles(3);
    check("flush_pre", first_done(1'b0, 3), -1);
    if_flush = 1'b1; if_addr = 32'h4;
    run_cycles(1);
    check("flush_cyc_done", t_ifd[0], 1'b0);
    if_flush = 1'b0;
    run_cycles(9);
    check("flush_hold", t_inst[5], 32'hDEADBEEF);
    check("flush_new_addr", t_addr[1], 32'h4);
    check("flush_new_done", first_done(1'b0, 9), 6);
    check("flush_once", count_done(1'b0, 9), 1);
    check("flush_new_inst", t_inst[6], 32'h00500013);
    sv = '0;
    for (int c = 0; c < 8; c++) sv[c] = t_we[c];
    check("flush_no_we", sv, 8'h00);

    // Reset in G+2 of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = 32'hCAFEF00D;
    run_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_b1", {ram_we, ram_addr, ram_dout}, {1'b1, 32'h501, 8'hF0});
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {if_inst, mem_rdata, if_done, mem_done, ram_addr, ram_we, ram_dout},
          128'h0);
    @(posedge clk); #1;
    run_cycles(6);
    check("rst_mid_nodone", count_done(1'b1, 6), 0);
    check("rst_mid_ram", {peek(32'h500), peek(32'h501), peek(32'h502), peek(32'h503)},
          32'h0DF0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide program/data RAM port between the instruction-fetch stage and the MEM stage. It serialises each 32-bit (or 8/16-bit) request into consecutive byte accesses and assembles little-endian read words. It returns completion pulses to the requesters and drives the pipeline stall request while any request is outstanding. It sits between the IF and MEM stages and the RAM, replacing direct combinational instruction-memory reads.

## Interface
- ADDR_W, 32, byte address width of requests and RAM port.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  abandon any fetch in progress (taken branch/jump).
- if_inst  out  32  fetched instruction, little-endian assembled.
- if_done  out  1  one-cycle pulse: if_inst valid this cycle.
- mem_req  in  1  data request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  00 byte, 01 half, 10 and 11 word.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  32  store data; byte k = bits [8k+7:8k].
- mem_rdata  out  32  load result, zero-extended.
- mem_done  out  1  one-cycle pulse: load data valid or store complete.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_we  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte, valid the cycle after its address.
- stall_req  out  1  pipeline stall request.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: on an edge with mem_req=1, grant MEM; else with if_req=1 (and if_flush=0), grant IF. MEM has strict priority.
- At the grant edge, latch source, base address, n (1/2/4; IF always 4, read), we, and wdata. Set k=0 and go to ACCESS.
- ACCESS: ram_addr = base+k (mod 2^ADDR_W, no alignment requirement), ram_we = we, ram_dout = wdata byte k. k increments each cycle.
  - After byte n-1: a read goes to WAIT; a write goes to DONE.
- Read capture: ram_din seen in the cycle after byte k's address is stored into result bits [8k+7:8k]. Unused upper bytes are 0.
- WAIT: captures the final byte, then goes to DONE.
- DONE: assert if_done or mem_done for exactly this cycle, then go to IDLE.
  - if_inst or mem_rdata updates at the entry to DONE and holds until that source's next DONE.
- A request seen high in IDLE is a new request. A requester must drop its req, or present the next request, in the cycle after its done.
- if_flush=1 while an IF transaction is in ACCESS, WAIT or DONE: abort at that edge.
  - No if_done; if_inst unchanged; go to IDLE. A new request may be granted on the following edge.
  - if_flush has no effect on MEM transactions.
  - if_flush in IDLE suppresses the IF grant that edge.
- stall_req = (if_req & ~if_done) | (mem_req & ~mem_done), combinational.
- Outside ACCESS: ram_we=0, ram_addr=0, ram_dout=0.

## Timing
- Reset (rst=0 at an edge): state IDLE, k=0. All outputs 0: if_inst=0, mem_rdata=0, if_done=0, mem_done=0, ram_*=0.
  - stall_req still follows its combinational equation.
  - Reset mid-transaction aborts it: no done pulse, no further RAM writes.
- Grant edge ends cycle G. Bytes are issued in cycles G+1..G+n.
- Read done: cycle G+n+2 (word fetch/load: G+6; byte: G+3).
- Write done: cycle G+n+1 (word store: G+5).
- Back-to-back: the next grant is at the edge ending the cycle after DONE (IDLE cycle). Minimum word-fetch period is 7 cycles.
- Simultaneous if_req and mem_req in IDLE: MEM served first. IF is granted in the IDLE cycle after mem_done.
- Requests arriving during a transaction wait; they are not queued beyond the held req level.

## Test plan
- Reset, then IF word fetch at 0x00000004 with RAM bytes 13,00,50,00 at 0x4..0x7 -> addresses 4,5,6,7 in G+1..G+4; if_done in G+6 with if_inst=0x00500013; stall_req high G..G+5.
- MEM byte load at 0x00000103 (RAM=0xA5) with if_req also high -> MEM wins; mem_rdata=0x000000A5, mem_done at G+3; IF granted afterwards, if_done 7 cycles after mem_done.
- MEM word store 0xDEADBEEF at 0x200 -> ram_we=1 with EF,BE,AD,DE at 0x200..0x203; mem_done at G+5; readback by a word load returns 0xDEADBEEF.
- Half store at 0xFFFFFFFF -> bytes written at 0xFFFFFFFF then 0x00000000 (wrap).
- if_flush in G+3 of a fetch -> no if_done, if_inst unchanged, ram_we stays 0; new fetch at the new address is granted the next edge and completes normally.
- rst=0 in G+2 of a word store -> only bytes 0 and 1 written, no mem_done; all outputs 0 next cycle.
